// File: rtl/venus_soc_pkg.sv
// Shared DMA FIFO defaults and the per-channel status bundle.
package venus_soc_pkg;
  localparam int DMA_CHANNELS = 4;
  localparam int DMA_SLOTS    = 128;
  localparam int DMA_WIDTH    = 128;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_status_t;
endpackage

// File: rtl/dma_fifo_ptr.sv
// Per-channel read/write pointers, occupancy and status flags; pointers advance one cycle after push/pop.
// Push/pop arrive pre-qualified by the top, so no full/empty checks are repeated here.
module dma_fifo_ptr
  import venus_soc_pkg::*;
#(
  parameter int SLOTS     = DMA_SLOTS,
  parameter int AF_THRESH = SLOTS - 2,
  parameter int AE_THRESH = 2,
  localparam int AW       = $clog2(SLOTS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  output logic [AW:0]  wptr_o,
  output logic [AW:0]  rptr_o,
  output logic [AW:0]  count_o,
  output fifo_status_t status_o
);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + ONE;
      if (pop_i)  rptr_d = rptr_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Pointers carry one wrap bit, so the modular difference is the occupancy 0..SLOTS.
  assign count_o = wptr_q - rptr_q;
  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;

  assign status_o.full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign status_o.empty  = (wptr_q == rptr_q);
  assign status_o.afull  = int'(count_o) >= AF_THRESH;
  assign status_o.aempty = int'(count_o) <= AE_THRESH;
endmodule

// File: rtl/dma_mc_fifo.sv
// Multi-channel FIFO over one flat storage array; reads return one cycle after the request.
// Writes stall via wr_ready_o on a full channel; dropped writes and empty reads raise sticky errors.
module dma_mc_fifo
  import venus_soc_pkg::*;
#(
  parameter int  CHANNELS  = DMA_CHANNELS,
  parameter int  SLOTS     = DMA_SLOTS,
  parameter int  WIDTH     = DMA_WIDTH,
  parameter int  AF_THRESH = SLOTS - 2,
  parameter int  AE_THRESH = 2,
  localparam int CW        = $clog2(CHANNELS > 1 ? CHANNELS : 2),
  localparam int AW        = $clog2(SLOTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic [CHANNELS-1:0]          clear_ch_i,
  input  logic                         wr_valid_i,
  input  logic [CW-1:0]                wr_ch_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  output logic                         wr_ready_o,
  input  logic                         rd_req_i,
  input  logic [CW-1:0]                rd_ch_i,
  output logic                         rd_valid_o,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic [CW-1:0]                rd_ch_o,
  output logic [CHANNELS-1:0]          full_o,
  output logic [CHANNELS-1:0]          empty_o,
  output logic [CHANNELS-1:0]          afull_o,
  output logic [CHANNELS-1:0]          aempty_o,
  output logic [CHANNELS-1:0][AW:0]    count_o,
  output logic                         ovf_err_o,
  output logic                         udf_err_o
);
  if (CHANNELS < 1 || (CHANNELS & (CHANNELS - 1)) != 0) begin : g_bad_channels
    $error("dma_mc_fifo: CHANNELS must be a power of 2 and >= 1");
  end
  if (SLOTS < 2 || (SLOTS & (SLOTS - 1)) != 0) begin : g_bad_slots
    $error("dma_mc_fifo: SLOTS must be a power of 2 and >= 2");
  end
  if (!(AE_THRESH < AF_THRESH && AF_THRESH <= SLOTS)) begin : g_bad_thresh
    $error("dma_mc_fifo: need AE_THRESH < AF_THRESH <= SLOTS");
  end

  logic [WIDTH-1:0]    mem [CHANNELS*SLOTS];
  logic [AW:0]         wptr [CHANNELS];
  logic [AW:0]         rptr [CHANNELS];
  fifo_status_t        st   [CHANNELS];
  logic [CHANNELS-1:0] clr, push, pop;
  logic [CW-1:0]       wch, rch;
  logic                wr_fire, rd_fire;
  logic                rd_valid_q;
  logic [WIDTH-1:0]    rd_data_q;
  logic [CW-1:0]       rd_ch_q;
  logic                ovf_q, ovf_d, udf_q, udf_d;

  // Masking keeps out-of-range channel selects inside the array when CHANNELS == 1.
  assign wch = wr_ch_i & CW'(CHANNELS - 1);
  assign rch = rd_ch_i & CW'(CHANNELS - 1);
  assign clr = {CHANNELS{clear_i}} | clear_ch_i;

  assign wr_ready_o = !full_o[wch];
  assign wr_fire    = wr_valid_i && wr_ready_o && !clr[wch];
  assign rd_fire    = rd_req_i && !empty_o[rch] && !clr[rch];

  always_comb begin
    push      = '0;
    pop       = '0;
    push[wch] = wr_fire;
    pop[rch]  = rd_fire;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    dma_fifo_ptr #(
      .SLOTS     (SLOTS),
      .AF_THRESH (AF_THRESH),
      .AE_THRESH (AE_THRESH)
    ) u_ptr (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clr[c]),
      .push_i   (push[c]),
      .pop_i    (pop[c]),
      .wptr_o   (wptr[c]),
      .rptr_o   (rptr[c]),
      .count_o  (count_o[c]),
      .status_o (st[c])
    );
    assign full_o[c]   = st[c].full;
    assign empty_o[c]  = st[c].empty;
    assign afull_o[c]  = st[c].afull;
    assign aempty_o[c] = st[c].aempty;
  end

  // Storage is never reset; the rst gate abandons a write racing reset assertion.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) mem[{wch, wptr[wch][AW-1:0]}] <= wr_data_i;
  end

  always_comb begin
    ovf_d = ovf_q | (wr_valid_i && !wr_ready_o && !clr[wch]);
    udf_d = udf_q | (rd_req_i && empty_o[rch] && !clr[rch]);
    if (clear_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ch_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= mem[{rch, rptr[rch][AW-1:0]}];
        rd_ch_q   <= rch;
      end
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_ch_o    = rd_ch_q;
  assign ovf_err_o  = ovf_q;
  assign udf_err_o  = udf_q;
endmodule

// File: tb/tb_dma_mc_fifo.sv
// Directed bench for dma_mc_fifo at CHANNELS=4, SLOTS=8, WIDTH=32, AF=6, AE=2.
module tb_dma_mc_fifo;
  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic [3:0]       clear_ch;
  logic             wr_valid;
  logic [1:0]       wr_ch;
  logic [31:0]      wr_data;
  logic             wr_ready;
  logic             rd_req;
  logic [1:0]       rd_ch;
  logic             rd_valid;
  logic [31:0]      rd_data;
  logic [1:0]       rd_ch_o;
  logic [3:0]       full, empty, afull, aempty;
  logic [3:0][3:0]  count;
  logic             ovf, udf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] q[$];
  logic [31:0] exp_d;

  dma_mc_fifo #(
    .CHANNELS (4), .SLOTS (8), .WIDTH (32), .AF_THRESH (6), .AE_THRESH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .clear_ch_i (clear_ch),
    .wr_valid_i (wr_valid),
    .wr_ch_i    (wr_ch),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .rd_req_i   (rd_req),
    .rd_ch_i    (rd_ch),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .rd_ch_o    (rd_ch_o),
    .full_o     (full),
    .empty_o    (empty),
    .afull_o    (afull),
    .aempty_o   (aempty),
    .count_o    (count),
    .ovf_err_o  (ovf),
    .udf_err_o  (udf)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear    = 1'b0;
    clear_ch = 4'b0;
    wr_valid = 1'b0;
    wr_ch    = 2'd0;
    wr_data  = 32'h0;
    rd_req   = 1'b0;
    rd_ch    = 2'd0;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk_eq({tag, "_rd_valid"}, rd_valid, 0);
    chk_eq({tag, "_rd_data"}, rd_data, 0);
    chk_eq({tag, "_rd_ch"}, rd_ch_o, 0);
    chk_eq({tag, "_empty"}, empty, 4'hF);
    chk_eq({tag, "_aempty"}, aempty, 4'hF);
    chk_eq({tag, "_full"}, full, 0);
    chk_eq({tag, "_afull"}, afull, 0);
    chk_eq({tag, "_count"}, count, 16'h0);
    chk_eq({tag, "_ovf"}, ovf, 0);
    chk_eq({tag, "_udf"}, udf, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12;
    chk_reset_state("reset");
    tick();
    rst = 1'b0;

    // Fill ch2 to full, then overflow it.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_ch = 2'd2; wr_data = 32'h10 + 32'(i);
      chk_eq("fill_ready", wr_ready, 1);
      tick();
      chk_eq("fill_count", count[2], 64'(i + 1));
      chk_eq("fill_afull", afull[2], (i + 1) >= 6);
      chk_eq("fill_aempty", aempty[2], (i + 1) <= 2);
      chk_eq("fill_full", full[2], (i + 1) == 8);
    end
    chk_eq("full_ready", wr_ready, 0);
    wr_data = 32'h99;
    tick();
    chk_eq("ovf_flag", ovf, 1);
    chk_eq("ovf_count", count[2], 8);
    idle();

    // Drain ch2 back-to-back, then underflow it.
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1; rd_ch = 2'd2;
      tick();
      chk_eq("drain_valid", rd_valid, 1);
      chk_eq("drain_data", rd_data, 32'h10 + 32'(i));
      chk_eq("drain_ch", rd_ch_o, 2);
      chk_eq("drain_count", count[2], 64'(7 - i));
    end
    tick();
    chk_eq("udf_valid", rd_valid, 0);
    chk_eq("udf_flag", udf, 1);
    chk_eq("udf_hold_data", rd_data, 32'h17);
    chk_eq("udf_empty", empty[2], 1);
    idle();

    // ch1 wrap with simultaneous write+read.
    q = {};
    for (int i = 0; i < 3; i++) begin
      wr(2'd1, 32'h50 + 32'(i));
      q.push_back(32'h50 + 32'(i));
    end
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1; wr_ch = 2'd1; wr_data = 32'h60 + 32'(i);
      rd_req = 1'b1; rd_ch = 2'd1;
      exp_d = q.pop_front();
      q.push_back(32'h60 + 32'(i));
      tick();
      chk_eq("wrap_data", rd_data, exp_d);
      chk_eq("wrap_valid", rd_valid, 1);
      chk_eq("wrap_count", count[1], 3);
    end
    idle();

    // Writes to ch0 interleaved with reads from ch3.
    for (int i = 0; i < 4; i++) wr(2'd3, 32'hB0 + 32'(i));
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1; wr_ch = 2'd0; wr_data = 32'hA0 + 32'(k);
      rd_req = 1'b1; rd_ch = 2'd3;
      tick();
      chk_eq("xch_data", rd_data, 32'hB0 + 32'(k));
      chk_eq("xch_ch", rd_ch_o, 3);
      chk_eq("xch_count0", count[0], 64'(k + 1));
      chk_eq("xch_count3", count[3], 64'(3 - k));
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      rd_req = 1'b1; rd_ch = 2'd0;
      tick();
      chk_eq("ch0_data", rd_data, 32'hA0 + 32'(k));
    end
    idle();

    // Global clear beats a same-cycle write and drops the sticky flags.
    clear = 1'b1; wr_valid = 1'b1; wr_ch = 2'd0; wr_data = 32'hDEAD;
    tick();
    idle();
    chk_eq("clr_ovf", ovf, 0);
    chk_eq("clr_udf", udf, 0);
    chk_eq("clr_empty", empty, 4'hF);

    // Per-channel clear of ch1 (5 entries) with a same-cycle write.
    for (int i = 0; i < 5; i++) wr(2'd1, 32'hD0 + 32'(i));
    wr(2'd0, 32'hC0);
    chk_eq("pre_clrch_count1", count[1], 5);
    clear_ch = 4'b0010; wr_valid = 1'b1; wr_ch = 2'd1; wr_data = 32'hEE;
    tick();
    chk_eq("clrch_count1", count[1], 0);
    chk_eq("clrch_ovf", ovf, 0);
    chk_eq("clrch_count0", count[0], 1);
    chk_eq("clrch_empty", empty, 4'b1110);
    wr_valid = 1'b0; rd_req = 1'b1; rd_ch = 2'd1;
    tick();
    chk_eq("clrch_rd_udf", udf, 0);
    chk_eq("clrch_rd_valid", rd_valid, 0);
    clear_ch = 4'b0; rd_ch = 2'd0;
    tick();
    chk_eq("ch0_intact_valid", rd_valid, 1);
    chk_eq("ch0_intact_data", rd_data, 32'hC0);
    idle();

    // Reset asserted mid-burst.
    rd_req = 1'b1; rd_ch = 2'd0;
    tick();
    chk_eq("pre_rst_udf", udf, 1);
    idle();
    for (int i = 0; i < 4; i++) wr(2'd2, 32'hF0 + 32'(i));
    rd_req = 1'b1; rd_ch = 2'd2;
    tick();
    chk_eq("burst_data", rd_data, 32'hF0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("midrst");
    tick();
    rst = 1'b0;
    tick();
    chk_eq("post_rst_valid", rd_valid, 0);
    chk_eq("post_rst_udf", udf, 1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
